fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the architectural PC of the SimpleRISC core and sequences instruction fetch over a req/ack instruction-memory handshake.
- Presents each fetched instruction with its PC to decode/immediate generation through a valid/ready handshake.
- Accepts redirects from execute (taken branch, call, ret), where the target is the immediate-generator branch target or the ret register value.
- Discards in-flight fetches made stale by a redirect, and flags an instruction-memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- TIMEOUT, 255, max cycles imem_req may stay unacknowledged before fetch_err; 8-bit counter, 0 disables the timeout.

Ports:
- clk  input  1  Single clock; all state changes on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- imem_req  output  1  Fetch request; held until imem_ack.
- imem_addr  output  32  Byte address of the fetch; stable while imem_req=1.
- imem_ack  input  1  Memory accepts the request and returns imem_rdata in the same cycle.
- imem_rdata  input  32  Instruction word; valid only when imem_ack=1.
- if_valid  output  1  if_instr/if_pc hold a valid instruction.
- if_ready  input  1  Downstream accepts the instruction when if_valid & if_ready.
- if_pc  output  32  PC of the presented instruction.
- if_instr  output  32  Presented instruction word.
- redirect  input  1  One-cycle pulse: change the fetch stream.
- redirect_pc  input  32  New PC; bits [1:0] are forced to 0 on use.
- fetch_err  output  1  Sticky timeout flag.

Behaviour:
- Reset (async assert): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, fetch_err=0, wait counter=0.
- States: IDLE, REQ, HOLD, DRAIN, ERR. A registered PC register is the source of imem_addr.
- IDLE:
  - Next cycle goes to REQ with imem_req=1, imem_addr=pc.
  - A redirect in IDLE loads pc first.
- REQ:
  - imem_req=1. On imem_ack: if_instr<=imem_rdata, if_pc<=pc, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC+4=0), if_valid<=1, go to HOLD.
  - Minimum latency from request to if_valid is 1 cycle after ack.
- HOLD:
  - if_valid=1 and imem_req=0; if_pc/if_instr are stable until accepted.
  - On if_ready, go to REQ. The next request is issued in the cycle after acceptance, giving a throughput of one instruction per 2 cycles minimum with zero-wait memory.
- Redirect, which has the highest priority:
  - Always: pc<=redirect_pc&~3, and if_valid<=0 (any unaccepted instruction is dropped even if if_ready is high the same cycle).
  - In REQ without ack the same cycle: go to DRAIN, keeping imem_req=1 with the old imem_addr.
  - In REQ with ack the same cycle: drop the data and go to REQ with the new address next cycle.
  - In HOLD or IDLE: go to REQ with the new pc.
  - In DRAIN: update pc only and stay in DRAIN.
- DRAIN: on imem_ack, discard rdata and go to REQ with imem_addr=pc.
- Timeout:
  - The wait counter increments each cycle in REQ or DRAIN with imem_ack=0, and clears on ack or on leaving those states.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT: fetch_err<=1, go to ERR.
  - ERR: imem_req=0, if_valid=0. Only a redirect (go to REQ, new pc) or reset leaves ERR. fetch_err stays set until reset.
- Simultaneous events:
  - redirect with imem_ack in DRAIN: discard the data and go to REQ with the redirected pc.
  - redirect in the timeout cycle: the redirect wins, no error is raised, and the request is drained.

Decomposition:
- Shared package simplerisc_pkg holds:
  - The state enum (IDLE, REQ, HOLD, DRAIN, ERR).
  - INSTR_BYTES=4.
  - The RESET_PC default constant.
- Sub-module fetch_timeout_ctr: an 8-bit counter with inc/clr/limit and an expired output. It is the only natural split; the FSM and PC stay in the top.

Test Plan:
- Reset release, zero-wait memory, if_ready=1: imem_addr sequence 0x0,0x4,0x8; if_pc/if_instr match; if_valid high every second cycle.
- Memory acks after 3 cycles while if_ready is held low for 5 cycles in HOLD:
  - imem_addr is stable throughout the wait.
  - if_pc/if_instr are stable throughout HOLD.
  - No second request is issued before acceptance.
- Redirect to 0x103 while REQ is waiting (ack 2 cycles later):
  - imem_req is held at the old address and the acked data is discarded.
  - The next request goes to 0x100 and if_pc=0x100.
- Redirect to 0x40 in HOLD with if_ready=1 the same cycle: the held instruction is not delivered; the next if_pc=0x40.
- TIMEOUT=4, no ack: fetch_err=1 after 4 waiting cycles and imem_req=0. A subsequent redirect to 0x80 resumes fetch at 0x80 with fetch_err still 1.
- rst_n asserted mid-DRAIN: outputs clear immediately (asynchronously); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared types and constants for the SimpleRISC front end.
package simplerisc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_DRAIN,
    ST_ERR
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles an instruction-memory request waits for ack; expired_o fires on
// the waiting cycle that would bring the count up to limit_i (limit 0 = never).
module fetch_timeout_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       clr_i,
  input  logic [7:0] limit_i,
  output logic       expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = inc_i && (limit_i != 8'd0) && (cnt_q == limit_i - 8'd1);

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and sequences instruction fetch over imem req/ack,
// presenting each instruction to decode through a valid/ready handshake.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | out of reset, request issued next cycle
//   ST_REQ   | imem_req high at pc, waiting for imem_ack
//   ST_HOLD  | instruction presented, waiting for if_ready
//   ST_DRAIN | stale request still outstanding after a redirect
//   ST_ERR   | memory timed out, parked until redirect or reset
module fetch_sequencer
  import simplerisc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  ifpc_q, ifpc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic         tmo_inc, tmo_clr, tmo_expired;

  fetch_timeout_ctr u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (tmo_inc),
    .clr_i     (tmo_clr),
    .limit_i   (TIMEOUT),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    tmo_inc = 1'b0;
    tmo_clr = 1'b1;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        tmo_inc = !imem_ack;
        tmo_clr = imem_ack;
        if (imem_ack) begin
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          pc_d    = pc_q + 32'(INSTR_BYTES);
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (if_ready) begin
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        tmo_inc = !imem_ack;
        tmo_clr = imem_ack;
        if (imem_ack) begin
          state_d = ST_REQ;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides everything above, including a same-cycle timeout;
    // an unacked request must still be drained before the new fetch starts.
    if (redirect) begin
      pc_d    = align_pc(redirect_pc);
      valid_d = 1'b0;
      err_d   = err_q;
      tmo_clr = 1'b1;
      if ((state_q == ST_REQ || state_q == ST_DRAIN) && !imem_ack) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  // imem_addr only moves when a fresh request starts, so it stays put in DRAIN.
  assign addr_d = (state_d == ST_REQ) ? pc_d : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= 32'd0;
      ifpc_q  <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_pc     = ifpc_q;
  assign if_instr  = instr_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized phase checked
// against an instruction-stream model (expected next PC, memory contents).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        fetch_err;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(8'd4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_deliv = 0;
  logic [31:0] exp_pc = 32'h0;
  int          fixed_delay = 0;
  int          wait_left = 0;
  bit          req_active = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Instruction memory: each new request waits wait_left cycles, then acks.
  task automatic mem_drive();
    if (!imem_req) begin
      req_active = 1'b0;
      imem_ack   = 1'b0;
    end else begin
      if (!req_active) begin
        req_active = 1'b1;
        wait_left  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
      end
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        req_active = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_left--;
      end
    end
  endtask

  // Stream model: a redirect retargets the stream, an acceptance must be the
  // next expected PC with its memory word.
  task automatic cycle();
    if (rst_n) begin
      if (redirect) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (if_valid && if_ready) begin
        check("deliv_pc", if_pc, exp_pc);
        check("deliv_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    mem_drive();
  endtask

  initial begin
    #3;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", if_valid, 0);
    check("rst_pc", if_pc, 0);
    check("rst_instr", if_instr, 0);
    check("rst_err", fetch_err, 0);

    // Zero-wait memory, downstream always ready.
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    if_ready    = 1'b1;
    fixed_delay = 0;
    mem_drive();
    cycle();
    for (int k = 0; k < 3; k++) begin
      check("zw_req", imem_req, 1);
      check("zw_addr", imem_addr, 32'(4 * k));
      check("zw_valid_lo", if_valid, 0);
      cycle();
      check("zw_valid_hi", if_valid, 1);
      check("zw_pc", if_pc, 32'(4 * k));
      check("zw_instr", if_instr, mem_word(32'(4 * k)));
      check("zw_req_lo", imem_req, 0);
      if (k == 2) fixed_delay = 3;
      cycle();
    end

    // Slow memory (3 wait cycles), then 5 cycles of backpressure.
    if_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("slow_req", imem_req, 1);
      check("slow_addr", imem_addr, 32'hC);
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", if_valid, 1);
      check("bp_pc", if_pc, 32'hC);
      check("bp_instr", if_instr, mem_word(32'hC));
      check("bp_req", imem_req, 0);
      cycle();
    end
    if_ready    = 1'b1;
    fixed_delay = 2;
    cycle();
    check("bp_next_addr", imem_addr, 32'h10);

    // Redirect to 0x103 while the request to 0x10 is still waiting.
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    cycle();
    check("drain_req", imem_req, 1);
    check("drain_addr", imem_addr, 32'h10);
    check("drain_valid", if_valid, 0);
    cycle();
    check("drain_ack_addr", imem_addr, 32'h10);
    fixed_delay = 0;
    cycle();
    check("rd_addr", imem_addr, 32'h100);
    check("rd_valid", if_valid, 0);
    cycle();
    check("rd_pc", if_pc, 32'h100);

    // Redirect in HOLD with if_ready high: held 0x100 is dropped.
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    check("hold_rd_valid", if_valid, 0);
    check("hold_rd_addr", imem_addr, 32'h40);
    cycle();
    check("hold_rd_pc", if_pc, 32'h40);

    // No ack: timeout after 4 waiting cycles.
    fixed_delay = 100;
    cycle();
    for (int k = 0; k < 4; k++) begin
      check("tmo_wait_err", fetch_err, 0);
      check("tmo_wait_req", imem_req, 1);
      cycle();
    end
    check("tmo_err", fetch_err, 1);
    check("tmo_req", imem_req, 0);
    check("tmo_valid", if_valid, 0);
    cycle();
    check("tmo_err_park", imem_req, 0);
    fixed_delay = 0;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    cycle();
    check("tmo_rd_addr", imem_addr, 32'h80);
    check("tmo_rd_req", imem_req, 1);
    check("tmo_sticky", fetch_err, 1);
    cycle();
    check("tmo_rd_pc", if_pc, 32'h80);

    // Async reset in the middle of DRAIN.
    fixed_delay = 5;
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    check("pre_rst_req", imem_req, 1);
    check("pre_rst_addr", imem_addr, 32'h84);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_valid", if_valid, 0);
    check("arst_pc", if_pc, 0);
    check("arst_err", fetch_err, 0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    exp_pc      = 32'h0;
    req_active  = 1'b0;
    fixed_delay = 0;
    mem_drive();
    cycle();
    check("restart_addr", imem_addr, 0);
    check("restart_req", imem_req, 1);
    cycle();
    check("restart_pc", if_pc, 0);

    // PC wrap from 0xFFFF_FFFC to 0.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    cycle();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    cycle();
    check("wrap_next_addr", imem_addr, 32'h0);

    // Randomized traffic, delays short enough to never time out.
    fixed_delay = -1;
    n_deliv     = 0;
    for (int k = 0; k < 400; k++) begin
      if_ready    = ($urandom_range(0, 1) == 1);
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom;
      if (prev_req && !prev_ack) begin
        check("rnd_req_held", imem_req, 1);
        check("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (imem_req && if_valid) check("rnd_req_vs_valid", 1, 0);
      check("rnd_no_err", fetch_err, 0);
      cycle();
    end
    check("rnd_deliveries", 32'(n_deliv >= 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
